// File: rtl/pc_update_ctrl.sv
// pc_update_ctrl: sequences PC updates and the multi-cycle exception entry for the multicycle core.
// Optional target alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_update_ctrl #(
    parameter int EXC_WAIT_CYCLES = 2,
    parameter int CAUSE_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seq_req,
    input  logic               br_req,
    input  logic               br_taken,
    input  logic               jmp_req,
    input  logic               eret_req,
    input  logic               exc_req,
    input  logic [CAUSE_W-1:0] exc_cause,
    input  logic [1:0]         target_low,
    output logic [2:0]         pc_sel,
    output logic               pc_write,
    output logic               epc_write,
    output logic               cause_write,
    output logic [CAUSE_W-1:0] cause,
    output logic               vec_rd,
    output logic               busy,
    output logic               done
);
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif
    localparam int CW = $clog2(EXC_WAIT_CYCLES + 1);

    typedef enum logic [2:0] {BOOT, IDLE, ISSUE, EXC_SAVE, EXC_VEC, EXC_LOAD} state_t;
    typedef enum logic [1:0] {K_SEQ, K_BR, K_JMP, K_ERET} kind_t;

    state_t             state, state_n;
    kind_t              kind;
    logic               taken;
    logic [CAUSE_W-1:0] cause_q;
    logic [2:0]         sel_q;
    logic [CW-1:0]      cnt;
    logic               run, any_req, checked, misalign;
    logic [2:0]         kind_sel;

    // outputs are masked while reset is held so an aborted sequence never writes
    assign run     = !reset;
    assign any_req = exc_req | eret_req | jmp_req | br_req | seq_req;

    always_comb begin
        kind_sel = kind == K_ERET ? 3'b000 : kind == K_JMP ? 3'b011 : kind == K_BR ? 3'b010 : 3'b100;
        checked  = kind != K_SEQ && (kind != K_BR || taken);
        misalign = ALIGN_EN && checked && |target_low;
        state_n  = state;
        case (state)
            BOOT:     state_n = IDLE;
            IDLE:     state_n = exc_req ? EXC_SAVE : any_req ? ISSUE : IDLE;
            ISSUE:    state_n = misalign ? EXC_SAVE : IDLE;
            EXC_SAVE: state_n = EXC_VEC;
            EXC_VEC:  state_n = cnt == '0 ? EXC_LOAD : EXC_VEC;
            EXC_LOAD: state_n = IDLE;
            default:  state_n = BOOT;
        endcase
        pc_write    = run && (state == BOOT || state == EXC_LOAD ||
                      (state == ISSUE && !misalign && (kind != K_BR || taken)));
        epc_write   = run && state == EXC_SAVE;
        cause_write = run && state == EXC_SAVE;
        cause       = cause_write ? cause_q : '0;
        vec_rd      = run && state == EXC_VEC;
        done        = run && (state == EXC_LOAD || (state == ISSUE && !misalign));
        busy        = reset || state != IDLE;
        pc_sel      = (reset || state == BOOT || state == EXC_LOAD) ? 3'b001 :
                      state == ISSUE ? kind_sel : sel_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BOOT;
            sel_q   <= 3'b001;
            cause_q <= '0;
            kind    <= K_SEQ;
            taken   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_n;
            sel_q <= pc_sel;
            if (state == IDLE) begin
                kind  <= eret_req ? K_ERET : jmp_req ? K_JMP : br_req ? K_BR : K_SEQ;
                taken <= br_taken;
                if (exc_req) cause_q <= exc_cause;
            end
            if (state == ISSUE && misalign) cause_q <= CAUSE_W'(2);
            if (state == EXC_SAVE) cnt <= CW'(EXC_WAIT_CYCLES - 1);
            else if (state == EXC_VEC) cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_pc_update_ctrl.sv
// tb_pc_update_ctrl: scoreboard bench; expected per-cycle output vectors are queued with the stimulus.
module tb_pc_update_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       seq_req = 0, br_req = 0, br_taken = 0, jmp_req = 0, eret_req = 0, exc_req = 0;
    logic [1:0] exc_cause = 0, target_low = 0;
    logic [2:0] pc_sel;
    logic       pc_write, epc_write, cause_write, vec_rd, busy, done;
    logic [1:0] cause;

    typedef struct {
        string       tag;
        int          cyc;
        logic [10:0] v;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;

    pc_update_ctrl dut (
        .clk(clk), .reset(reset), .seq_req(seq_req), .br_req(br_req), .br_taken(br_taken),
        .jmp_req(jmp_req), .eret_req(eret_req), .exc_req(exc_req), .exc_cause(exc_cause),
        .target_low(target_low), .pc_sel(pc_sel), .pc_write(pc_write), .epc_write(epc_write),
        .cause_write(cause_write), .cause(cause), .vec_rd(vec_rd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    // {pc_sel, pc_write, epc_write, cause_write, cause, vec_rd, busy, done}
    function automatic logic [10:0] ov(input logic [2:0] sel, input logic pw, input logic ew,
                                       input logic cw, input logic [1:0] c, input logic vr,
                                       input logic b, input logic d);
        return {sel, pw, ew, cw, c, vr, b, d};
    endfunction

    function automatic logic [10:0] idle(input logic [2:0] sel);
        return ov(sel, 0, 0, 0, 2'b00, 0, 0, 0);
    endfunction

    task automatic expect_at(input int ofs, input string tag, input logic [10:0] v);
        sb.push_back('{tag, cyc + ofs, v});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].cyc == cyc) begin
                check(sb[i].tag, 32'({pc_sel, pc_write, epc_write, cause_write, cause, vec_rd, busy, done}),
                      32'(sb[i].v));
                sb.delete(i);
            end
    end

    initial begin
        step;
        step;
        expect_at(0, "reset_held", ov(3'b001, 0, 0, 0, 2'b00, 0, 1, 0));
        step;
        reset = 0;
        expect_at(0, "boot", ov(3'b001, 1, 0, 0, 2'b00, 0, 1, 0));
        expect_at(1, "boot_idle", idle(3'b001));
        step; step;
        // sequential commit
        seq_req = 1;
        expect_at(0, "seq_idle", idle(3'b001));
        expect_at(1, "seq_issue", ov(3'b100, 1, 0, 0, 2'b00, 0, 1, 1));
        step; step;
        seq_req = 0;
        expect_at(0, "seq_hold_sel", idle(3'b100));
        step;
        // branch not taken, then taken
        br_req = 1; br_taken = 0;
        expect_at(1, "br_nt_issue", ov(3'b010, 0, 0, 0, 2'b00, 0, 1, 1));
        step; step;
        br_req = 0;
        expect_at(0, "br_nt_idle", idle(3'b010));
        step;
        br_req = 1; br_taken = 1;
        expect_at(1, "br_t_issue", ov(3'b010, 1, 0, 0, 2'b00, 0, 1, 1));
        step; step;
        br_req = 0; br_taken = 0;
        step;
        // exception entry
        exc_req = 1; exc_cause = 2'b01;
        expect_at(1, "exc_save", ov(3'b010, 0, 1, 1, 2'b01, 0, 1, 0));
        expect_at(2, "exc_vec0", ov(3'b010, 0, 0, 0, 2'b00, 1, 1, 0));
        expect_at(3, "exc_vec1", ov(3'b010, 0, 0, 0, 2'b00, 1, 1, 0));
        expect_at(4, "exc_load", ov(3'b001, 1, 0, 0, 2'b00, 0, 1, 1));
        repeat (5) step;
        exc_req = 0;
        expect_at(0, "exc_idle", idle(3'b001));
        step;
        // simultaneous exc + jmp + seq: served in priority order
        exc_req = 1; jmp_req = 1; seq_req = 1; exc_cause = 2'b11;
        expect_at(1, "pri_save", ov(3'b001, 0, 1, 1, 2'b11, 0, 1, 0));
        expect_at(2, "pri_vec0", ov(3'b001, 0, 0, 0, 2'b00, 1, 1, 0));
        expect_at(3, "pri_vec1", ov(3'b001, 0, 0, 0, 2'b00, 1, 1, 0));
        expect_at(4, "pri_load", ov(3'b001, 1, 0, 0, 2'b00, 0, 1, 1));
        repeat (5) step;
        exc_req = 0;
        expect_at(0, "pri_pend_idle", idle(3'b001));
        expect_at(1, "pri_jmp", ov(3'b011, 1, 0, 0, 2'b00, 0, 1, 1));
        step; step;
        jmp_req = 0;
        expect_at(0, "pri_idle2", idle(3'b011));
        expect_at(1, "pri_seq", ov(3'b100, 1, 0, 0, 2'b00, 0, 1, 1));
        step; step;
        seq_req = 0;
        expect_at(0, "pri_idle3", idle(3'b100));
        step;
        // eret, aligned target
        eret_req = 1;
        expect_at(1, "eret_issue", ov(3'b000, 1, 0, 0, 2'b00, 0, 1, 1));
        step; step;
        eret_req = 0;
        step;
        // seq is never alignment checked
        seq_req = 1; target_low = 2'b01;
        expect_at(1, "seq_misal", ov(3'b100, 1, 0, 0, 2'b00, 0, 1, 1));
        step; step;
        seq_req = 0;
        step;
        // misaligned jump
        jmp_req = 1; target_low = 2'b01;
`ifdef PC_ALIGN_CHECK_EN
        expect_at(1, "jmp_misal", ov(3'b011, 0, 0, 0, 2'b00, 0, 1, 0));
        expect_at(2, "misal_save", ov(3'b011, 0, 1, 1, 2'b10, 0, 1, 0));
        expect_at(3, "misal_vec0", ov(3'b011, 0, 0, 0, 2'b00, 1, 1, 0));
        expect_at(4, "misal_vec1", ov(3'b011, 0, 0, 0, 2'b00, 1, 1, 0));
        expect_at(5, "misal_load", ov(3'b001, 1, 0, 0, 2'b00, 0, 1, 1));
        repeat (6) step;
        jmp_req = 0; target_low = 0;
        expect_at(0, "misal_idle", idle(3'b001));
`else
        expect_at(1, "jmp_misal", ov(3'b011, 1, 0, 0, 2'b00, 0, 1, 1));
        step; step;
        jmp_req = 0; target_low = 0;
        expect_at(0, "misal_idle", idle(3'b011));
`endif
        step;
        // reset during EXC_VEC aborts without writes
        exc_req = 1; exc_cause = 2'b10;
        step; step;
        reset = 1;
        expect_at(0, "rst_in_vec", ov(3'b001, 0, 0, 0, 2'b00, 0, 1, 0));
        step;
        expect_at(0, "rst_in_vec2", ov(3'b001, 0, 0, 0, 2'b00, 0, 1, 0));
        step;
        reset = 0; exc_req = 0;
        expect_at(0, "reboot", ov(3'b001, 1, 0, 0, 2'b00, 0, 1, 0));
        expect_at(1, "reboot_idle", idle(3'b001));
        step; step; step;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
